// File: rtl/picture_pad_pkg.sv
// Shared definitions for the LCD picture padder and the Ethernet-side cropper:
// raster geometry, RGB565 colours and the per-pixel source-select encoding.
package picture_pad_pkg;

   // Both ends of the DDR frame buffer must agree on this geometry.
   localparam int GEO_H_TOTAL = 800;
   localparam int GEO_V_TOTAL = 480;
   localparam int GEO_X_START = 160;
   localparam int GEO_X_END   = 640;
   localparam int GEO_Y_START = 104;
   localparam int GEO_Y_END   = 376;

   localparam int PIX_CNT_W = 11;

   localparam logic [15:0] RGB565_BLACK = 16'h0000;
   localparam logic [15:0] RGB565_RED   = 16'hF800;

   typedef enum logic [1:0] {
      SRC_BORDER = 2'd0,
      SRC_FIFO   = 2'd1,
      SRC_UNDER  = 2'd2
   } src_sel_t;

endpackage

// File: rtl/picture_pad_raster_cnt.sv
// Raster x/y position counter: advances in raster order, wraps at the line and
// frame ends, and can be synchronously cleared in the same cycle as an advance.
module raster_cnt
   import picture_pad_pkg::*;
#(
   parameter int X_TOTAL = GEO_H_TOTAL,
   parameter int Y_TOTAL = GEO_V_TOTAL,
   parameter int CNT_W   = PIX_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             adv,
   output logic [CNT_W-1:0] cntx,
   output logic [CNT_W-1:0] cnty
);

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_TOTAL - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_TOTAL - 1);

   // A clear coinciding with an advance counts the cleared position as consumed.
   logic [CNT_W-1:0] x_base;
   logic [CNT_W-1:0] y_base;

   assign x_base = clr ? '0 : cntx;
   assign y_base = clr ? '0 : cnty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cntx <= '0;
         cnty <= '0;
      end else if (adv) begin
         if (x_base == X_LAST) begin
            cntx <= '0;
            cnty <= (y_base == Y_LAST) ? '0 : y_base + 1'b1;
         end else begin
            cntx <= x_base + 1'b1;
            cnty <= y_base;
         end
      end else if (clr) begin
         cntx <= '0;
         cnty <= '0;
      end
   end

endmodule

// File: rtl/picture_pad.sv
// Rebuilds the full LCD raster from the centred picture in the DDR read FIFO:
// window pixels come from the FIFO, everything else is a constant border colour.
module picture_pad
   import picture_pad_pkg::*;
#(
   parameter int          H_TOTAL      = GEO_H_TOTAL,
   parameter int          V_TOTAL      = GEO_V_TOTAL,
   parameter int          X_START      = GEO_X_START,
   parameter int          X_END        = GEO_X_END,
   parameter int          Y_START      = GEO_Y_START,
   parameter int          Y_END        = GEO_Y_END,
   parameter logic [15:0] BORDER_COLOR = RGB565_BLACK,
   parameter logic [15:0] UNDER_COLOR  = RGB565_RED
) (
   input  logic        lcd_clk,
   input  logic        sys_rst_n,
   input  logic        frame_start,
   input  logic        pixel_req,
   output logic        fifo_rd_en,
   input  logic [15:0] fifo_rd_data,
   input  logic        fifo_empty,
   output logic [15:0] pixel_data,
   output logic        pixel_vld,
   output logic [10:0] pixel_cntx,
   output logic [10:0] pixel_cnty,
   output logic        underflow,
   output logic [15:0] miss_cnt
);

   localparam logic ST_IDLE   = 1'b0;
   localparam logic ST_ACTIVE = 1'b1;

   localparam logic [10:0] X_LO = 11'(X_START);
   localparam logic [10:0] X_HI = 11'(X_END);
   localparam logic [10:0] Y_LO = 11'(Y_START);
   localparam logic [10:0] Y_HI = 11'(Y_END);

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic        state;
   logic [10:0] x_p0;
   logic [10:0] y_p0;
   logic        in_win_p0;
   src_sel_t    src_sel_p0;
   src_sel_t    src_sel_p1;
   logic        vld_p1;

   raster_cnt #(
      .X_TOTAL (H_TOTAL),
      .Y_TOTAL (V_TOTAL),
      .CNT_W   (11)
   ) u_raster_cnt (
      .clk   (lcd_clk),
      .rst_n (sys_rst_n),
      .clr   (frame_start),
      .adv   (pixel_req),
      .cntx  (pixel_cntx),
      .cnty  (pixel_cnty)
   );

   // --- p0: request cycle; a frame_start request is always pixel (0,0)
   assign x_p0      = frame_start ? '0 : pixel_cntx;
   assign y_p0      = frame_start ? '0 : pixel_cnty;
   assign in_win_p0 = (x_p0 >= X_LO) && (x_p0 < X_HI) && (y_p0 >= Y_LO) && (y_p0 < Y_HI);

   always_comb begin
      src_sel_p0 = SRC_BORDER;
      if ((state == ST_ACTIVE) && in_win_p0)
         src_sel_p0 = fifo_empty ? SRC_UNDER : SRC_FIFO;
   end

   assign fifo_rd_en = pixel_req && (src_sel_p0 == SRC_FIFO);

   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         src_sel_p1 <= SRC_BORDER;
         vld_p1     <= 1'b0;
         underflow  <= 1'b0;
         miss_cnt   <= '0;
      end else begin
         if (frame_start)
            state <= ST_ACTIVE;
         src_sel_p1 <= pixel_req ? src_sel_p0 : SRC_BORDER;
         vld_p1     <= pixel_req;
         if (frame_start) begin
            underflow <= 1'b0;
            miss_cnt  <= '0;
         end else if (pixel_req && (src_sel_p0 == SRC_UNDER)) begin
            underflow <= 1'b1;
            miss_cnt  <= sat_inc16(miss_cnt);
         end
      end
   end

   // --- p1: output pixel; FIFO data arrives this cycle from the p0 read
   always_comb begin
      case (src_sel_p1)
         SRC_FIFO:  pixel_data = fifo_rd_data;
         SRC_UNDER: pixel_data = UNDER_COLOR;
         default:   pixel_data = BORDER_COLOR;
      endcase
   end

   assign pixel_vld = vld_p1;

endmodule

// File: tb/tb_picture_pad.sv
// Directed bench for picture_pad on a reduced 16x10 raster with an 8x4 window
// at (4,3); a behavioural standard FIFO supplies 16'h1000 + word index.
module tb_picture_pad;

   localparam int HT  = 16;
   localparam int VT  = 10;
   localparam int XS  = 4;
   localparam int XE  = 12;
   localparam int YS  = 3;
   localparam int YE  = 7;
   localparam int WIN = (XE - XS) * (YE - YS);

   logic        lcd_clk = 1'b0;
   logic        sys_rst_n;
   logic        frame_start;
   logic        pixel_req;
   logic        fifo_rd_en;
   logic [15:0] fifo_rd_data = 16'h0;
   logic        fifo_empty;
   logic [15:0] pixel_data;
   logic        pixel_vld;
   logic [10:0] pixel_cntx;
   logic [10:0] pixel_cnty;
   logic        underflow;
   logic [15:0] miss_cnt;

   int   n_chk = 0;
   int   n_pass = 0;
   int   rd_ptr = 0;
   int   fifo_fill = 0;
   logic force_empty = 1'b0;

   logic        rd_o;
   logic        pv_o;
   logic [15:0] pd_o;
   int          cx_o;
   int          cy_o;

   picture_pad #(
      .H_TOTAL (HT), .V_TOTAL (VT),
      .X_START (XS), .X_END (XE),
      .Y_START (YS), .Y_END (YE),
      .BORDER_COLOR (16'h0000), .UNDER_COLOR (16'hF800)
   ) dut (
      .lcd_clk      (lcd_clk),
      .sys_rst_n    (sys_rst_n),
      .frame_start  (frame_start),
      .pixel_req    (pixel_req),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_empty   (fifo_empty),
      .pixel_data   (pixel_data),
      .pixel_vld    (pixel_vld),
      .pixel_cntx   (pixel_cntx),
      .pixel_cnty   (pixel_cnty),
      .underflow    (underflow),
      .miss_cnt     (miss_cnt)
   );

   always #5 lcd_clk = ~lcd_clk;

   assign fifo_empty = force_empty || (rd_ptr >= fifo_fill);

   always @(posedge lcd_clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= 16'h1000 + 16'(rd_ptr);
         rd_ptr       <= rd_ptr + 1;
      end
   end

   function automatic logic in_win(input int x, input int y);
      return (x >= XS) && (x < XE) && (y >= YS) && (y < YE);
   endfunction

   // One request slot: inputs set at negedge, request-cycle outputs captured
   // before the edge, the resulting pixel captured just after it.
   task automatic step(input logic fs, input logic req);
      @(negedge lcd_clk);
      frame_start = fs;
      pixel_req   = req;
      #1;
      rd_o = fifo_rd_en;
      cx_o = int'(pixel_cntx);
      cy_o = int'(pixel_cnty);
      @(posedge lcd_clk);
      #1;
      pd_o = pixel_data;
      pv_o = pixel_vld;
      frame_start = 1'b0;
      pixel_req   = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst_n   = 1'b0;
      frame_start = 1'b0;
      pixel_req   = 1'b1;
      repeat (3) @(negedge lcd_clk);
      #1;
      n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); else n_pass++;
      n_chk++; if (pixel_data !== 16'h0) $display("FAIL reset_data got %h want 0000", pixel_data); else n_pass++;
      n_chk++; if (pixel_vld !== 1'b0) $display("FAIL reset_vld got %b want 0", pixel_vld); else n_pass++;
      n_chk++; if ({pixel_cntx, pixel_cnty} !== 22'h0) $display("FAIL reset_cnt got (%0d,%0d) want (0,0)", pixel_cntx, pixel_cnty); else n_pass++;
      n_chk++; if (underflow !== 1'b0) $display("FAIL reset_underflow got %b want 0", underflow); else n_pass++;
      n_chk++; if (miss_cnt !== 16'h0) $display("FAIL reset_miss got %h want 0000", miss_cnt); else n_pass++;
      pixel_req = 1'b0;
      @(negedge lcd_clk);
      sys_rst_n = 1'b1;
   endtask

   task automatic test_idle();
      int n_rd = 0;
      int p0 = rd_ptr;
      fifo_fill = rd_ptr + WIN;
      for (int i = 0; i < HT; i++) begin
         step(1'b0, 1'b1);
         if (rd_o) n_rd++;
         n_chk++;
         if ({pv_o, pd_o} !== {1'b1, 16'h0000})
            $display("FAIL idle_pixel[%0d] got vld=%b data=%h want vld=1 data=0000", i, pv_o, pd_o);
         else n_pass++;
      end
      n_chk++; if (n_rd != 0) $display("FAIL idle_reads got %0d want 0", n_rd); else n_pass++;
      n_chk++; if (rd_ptr != p0) $display("FAIL idle_fifo_ptr got %0d want %0d", rd_ptr, p0); else n_pass++;
      n_chk++; if ({pixel_cntx, pixel_cnty} !== {11'd0, 11'd1}) $display("FAIL idle_wrap got (%0d,%0d) want (0,1)", pixel_cntx, pixel_cnty); else n_pass++;
   endtask

   task automatic test_full_frame();
      int base = rd_ptr;
      int k = 0;
      int n_rd = 0;
      int fx = -1, fy = -1, lx = -1, ly = -1;
      logic        exp_rd;
      logic [15:0] exp_pd;
      fifo_fill = base + WIN;
      step(1'b1, 1'b0);
      n_chk++; if (pv_o !== 1'b0) $display("FAIL frame_start_vld got %b want 0", pv_o); else n_pass++;
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            exp_rd = in_win(x, y);
            exp_pd = exp_rd ? 16'h1000 + 16'(base + k) : 16'h0000;
            step(1'b0, 1'b1);
            if (rd_o) begin
               n_rd++;
               if (fx < 0) begin fx = cx_o; fy = cy_o; end
               lx = cx_o; ly = cy_o;
            end
            n_chk++; if (cx_o != x || cy_o != y) $display("FAIL frame_pos got (%0d,%0d) want (%0d,%0d)", cx_o, cy_o, x, y); else n_pass++;
            n_chk++; if (rd_o !== exp_rd) $display("FAIL frame_rd_en at (%0d,%0d) got %b want %b", x, y, rd_o, exp_rd); else n_pass++;
            n_chk++; if (pd_o !== exp_pd) $display("FAIL frame_data at (%0d,%0d) got %h want %h", x, y, pd_o, exp_pd); else n_pass++;
            if (exp_rd) k++;
         end
      end
      n_chk++; if (n_rd != WIN) $display("FAIL frame_reads got %0d want %0d", n_rd, WIN); else n_pass++;
      n_chk++; if (fx != XS || fy != YS) $display("FAIL frame_first_read got (%0d,%0d) want (%0d,%0d)", fx, fy, XS, YS); else n_pass++;
      n_chk++; if (lx != XE-1 || ly != YE-1) $display("FAIL frame_last_read got (%0d,%0d) want (%0d,%0d)", lx, ly, XE-1, YE-1); else n_pass++;
      n_chk++; if (underflow !== 1'b0) $display("FAIL frame_underflow got %b want 0", underflow); else n_pass++;
      n_chk++; if (miss_cnt !== 16'h0) $display("FAIL frame_miss got %h want 0000", miss_cnt); else n_pass++;
   endtask

   task automatic test_underflow();
      int base = rd_ptr;
      int k = 0;
      int nread = 0;
      logic        w;
      logic        forced;
      logic [15:0] exp_pd;
      fifo_fill = base + WIN;
      step(1'b1, 1'b0);
      for (int y = 0; y < VT; y++) begin
         for (int x = 0; x < HT; x++) begin
            w      = in_win(x, y);
            forced = w && (k >= 10) && (k < 20);
            force_empty = forced;
            if (!w)        exp_pd = 16'h0000;
            else if (forced) exp_pd = 16'hF800;
            else begin
               exp_pd = 16'h1000 + 16'(base + nread);
               nread++;
            end
            step(1'b0, 1'b1);
            force_empty = 1'b0;
            n_chk++; if (pd_o !== exp_pd) $display("FAIL under_data at (%0d,%0d) got %h want %h", x, y, pd_o, exp_pd); else n_pass++;
            if (forced) begin
               n_chk++; if (rd_o !== 1'b0) $display("FAIL under_rd_en at (%0d,%0d) got %b want 0", x, y, rd_o); else n_pass++;
            end
            if (w) k++;
         end
      end
      n_chk++; if (miss_cnt !== 16'd10) $display("FAIL under_miss got %0d want 10", miss_cnt); else n_pass++;
      n_chk++; if (underflow !== 1'b1) $display("FAIL under_flag got %b want 1", underflow); else n_pass++;
      step(1'b1, 1'b0);
      n_chk++; if (miss_cnt !== 16'd0) $display("FAIL under_miss_clear got %0d want 0", miss_cnt); else n_pass++;
      n_chk++; if (underflow !== 1'b0) $display("FAIL under_flag_clear got %b want 0", underflow); else n_pass++;
   endtask

   task automatic test_resync();
      int n_rd = 0;
      logic [15:0] exp_pd;
      fifo_fill = rd_ptr + WIN;
      step(1'b1, 1'b0);
      for (int i = 0; i < 5*HT + 8; i++) step(1'b0, 1'b1);
      n_chk++; if ({pixel_cntx, pixel_cnty} !== {11'd8, 11'd5}) $display("FAIL resync_pre got (%0d,%0d) want (8,5)", pixel_cntx, pixel_cnty); else n_pass++;
      step(1'b1, 1'b0);
      n_chk++; if ({pixel_cntx, pixel_cnty} !== 22'h0) $display("FAIL resync_restart got (%0d,%0d) want (0,0)", pixel_cntx, pixel_cnty); else n_pass++;
      for (int i = 0; i < YS*HT + XS; i++) begin
         step(1'b0, 1'b1);
         if (rd_o) n_rd++;
      end
      n_chk++; if (n_rd != 0) $display("FAIL resync_early_reads got %0d want 0", n_rd); else n_pass++;
      exp_pd = 16'h1000 + 16'(rd_ptr);
      step(1'b0, 1'b1);
      n_chk++; if (rd_o !== 1'b1 || cx_o != XS || cy_o != YS) $display("FAIL resync_first_read got rd=%b at (%0d,%0d) want rd=1 at (%0d,%0d)", rd_o, cx_o, cy_o, XS, YS); else n_pass++;
      n_chk++; if (pd_o !== exp_pd) $display("FAIL resync_data got %h want %h", pd_o, exp_pd); else n_pass++;
   endtask

   task automatic test_coincident();
      // counters sit inside the window here, so a stale position would read
      step(1'b1, 1'b1);
      n_chk++; if (rd_o !== 1'b0) $display("FAIL coinc_rd_en got %b want 0", rd_o); else n_pass++;
      n_chk++; if ({pv_o, pd_o} !== {1'b1, 16'h0000}) $display("FAIL coinc_pixel got vld=%b data=%h want vld=1 data=0000", pv_o, pd_o); else n_pass++;
      n_chk++; if ({pixel_cntx, pixel_cnty} !== {11'd1, 11'd0}) $display("FAIL coinc_cnt got (%0d,%0d) want (1,0)", pixel_cntx, pixel_cnty); else n_pass++;
   endtask

   task automatic test_reset_burst();
      int n_rd = 0;
      int p0;
      fifo_fill = rd_ptr + WIN;
      step(1'b1, 1'b0);
      for (int i = 0; i < YS*HT + XS + 2; i++) step(1'b0, 1'b1);
      @(negedge lcd_clk);
      pixel_req = 1'b1;
      #1;
      n_chk++; if (fifo_rd_en !== 1'b1) $display("FAIL burst_pre_rd_en got %b want 1", fifo_rd_en); else n_pass++;
      sys_rst_n = 1'b0;
      #1;
      n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL burst_rd_en got %b want 0", fifo_rd_en); else n_pass++;
      n_chk++; if ({pixel_data, pixel_vld, underflow, miss_cnt} !== 34'h0) $display("FAIL burst_outputs got data=%h vld=%b uf=%b miss=%h want all 0", pixel_data, pixel_vld, underflow, miss_cnt); else n_pass++;
      n_chk++; if ({pixel_cntx, pixel_cnty} !== 22'h0) $display("FAIL burst_cnt got (%0d,%0d) want (0,0)", pixel_cntx, pixel_cnty); else n_pass++;
      pixel_req = 1'b0;
      @(negedge lcd_clk);
      sys_rst_n = 1'b1;
      p0 = rd_ptr;
      for (int i = 0; i < HT*VT; i++) begin
         step(1'b0, 1'b1);
         if (rd_o) n_rd++;
      end
      n_chk++; if (n_rd != 0 || rd_ptr != p0) $display("FAIL burst_idle_reads got %0d reads ptr %0d want 0 reads ptr %0d", n_rd, rd_ptr, p0); else n_pass++;
      step(1'b1, 1'b0);
      for (int i = 0; i < YS*HT + XS; i++) step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      n_chk++; if (rd_o !== 1'b1) $display("FAIL burst_restart_rd got %b want 1", rd_o); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle();
      test_full_frame();
      test_underflow();
      test_resync();
      test_coincident();
      test_reset_burst();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
